// File: rtl/busca_instrucao_fila.sv
// busca_instrucao_fila: instruction fetch stage with PC, ready/valid memory requests,
// in-flight squash on redirect and a prefetch queue feeding the ID stage.
module busca_instrucao_fila #(
   parameter int                     LARGURA      = 32,
   parameter int                     LARGURA_END  = 32,
   parameter int                     PROFUNDIDADE = 4,
   parameter logic [LARGURA_END-1:0] PC_RESET     = '0,
   parameter int                     INCREMENTO   = 4
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                PCescreve,
   input  logic                                desvio,
   input  logic [LARGURA_END-1:0]              destinoDesvio,
   output logic                                mem_req,
   output logic [LARGURA_END-1:0]              mem_end,
   input  logic                                mem_pronto,
   input  logic                                mem_valido,
   input  logic [LARGURA-1:0]                  mem_dado,
   output logic                                instr_valida,
   output logic [LARGURA-1:0]                  instrucao,
   output logic [LARGURA_END-1:0]              instr_pc,
   output logic [LARGURA_END-1:0]              saidaAdder,
   input  logic                                id_pronto,
   output logic [$clog2(PROFUNDIDADE+1)-1:0]   fila_nivel
);
   localparam int PW = $clog2(PROFUNDIDADE);
   localparam int NW = $clog2(PROFUNDIDADE+1);
   localparam logic [LARGURA_END-1:0] INC = LARGURA_END'(INCREMENTO);
   localparam logic [NW:0] PROF = (NW+1)'(PROFUNDIDADE);

   logic [LARGURA_END-1:0] pc, pc_resposta;
   logic [LARGURA-1:0]     fila_instr [PROFUNDIDADE];
   logic [LARGURA_END-1:0] fila_pc    [PROFUNDIDADE];
   logic [PW-1:0]          rd_ptr, wr_ptr;
   logic [NW-1:0]          nivel, pendentes, descartar;
   logic                   aceita, resposta, descarta, push, pop;

   // Credit: every outstanding request already owns a queue slot, so the queue cannot overflow.
   assign mem_req      = reset_n & PCescreve & ~desvio & (({1'b0, pendentes} + {1'b0, nivel}) < PROF);
   assign mem_end      = pc;
   assign aceita       = mem_req & mem_pronto;
   assign resposta     = mem_valido & (pendentes != '0);
   assign descarta     = resposta & (descartar != '0);
   assign push         = resposta & ~descarta & ~desvio;
   assign pop          = instr_valida & id_pronto & ~desvio;
   assign instr_valida = nivel != '0;
   assign instrucao    = fila_instr[rd_ptr];
   assign instr_pc     = fila_pc[rd_ptr];
   assign saidaAdder   = instr_pc + INC;
   assign fila_nivel   = nivel;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= PC_RESET;
         pc_resposta <= PC_RESET;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         nivel       <= '0;
         pendentes   <= '0;
         descartar   <= '0;
         for (int i = 0; i < PROFUNDIDADE; i++) begin
            fila_instr[i] <= '0;
            fila_pc[i]    <= PC_RESET;
         end
      end else if (desvio) begin
         // Everything still in flight belongs to the wrong path.
         pc          <= destinoDesvio;
         pc_resposta <= destinoDesvio;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         nivel       <= '0;
         pendentes   <= pendentes - NW'(resposta);
         descartar   <= pendentes - NW'(resposta);
      end else begin
         if (aceita)
            pc <= pc + INC;
         pendentes <= pendentes + NW'(aceita) - NW'(resposta);
         if (descarta)
            descartar <= descartar - NW'(1);
         if (push) begin
            fila_instr[wr_ptr] <= mem_dado;
            fila_pc[wr_ptr]    <= pc_resposta;
            wr_ptr             <= wr_ptr + PW'(1);
            pc_resposta        <= pc_resposta + INC;
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         nivel <= nivel + NW'(push) - NW'(pop);
      end
   end
endmodule

// File: tb/tb_busca_instrucao_fila.sv
// tb_busca_instrucao_fila: vector table, directed corner sequences and random traffic
// checked against a queue-level model of the fetch stage and its memory.
module tb_busca_instrucao_fila;
   logic        clock = 0, reset_n = 0;
   logic        PCescreve = 0, desvio = 0, mem_pronto = 0, mem_valido = 0, id_pronto = 0;
   logic [31:0] destinoDesvio = 0, mem_dado = 0;
   logic        mem_req, instr_valida;
   logic [31:0] mem_end, instrucao, instr_pc, saidaAdder;
   logic [2:0]  fila_nivel;

   logic        w_pce = 0, w_des = 0, w_mp = 0, w_mv = 0, w_idp = 0;
   logic [31:0] w_tgt = 0, w_dado = 0;
   logic        w_req, w_iv;
   logic [31:0] w_end, w_ins, w_ipc, w_sa;
   logic [2:0]  w_niv;

   int checks = 0, failures = 0, cyc = 0, lat = 1, n_acc = 0;
   bit stray = 0;

   typedef struct { logic [31:0] ins, pc; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mr_t;
   ent_t m_q[$];
   mr_t  mq[$];
   logic [31:0] m_pc, m_presp;
   int m_pend, m_disc;

   typedef struct {
      bit pce, idp, des; logic [31:0] tgt;
      bit mp, mv; logic [31:0] dado;
      bit e_req; logic [31:0] e_end;
      bit e_iv; logic [31:0] e_pc, e_ins; int e_niv;
   } vec_t;
   vec_t tab[12];

   busca_instrucao_fila dut (
      .clock(clock), .reset_n(reset_n), .PCescreve(PCescreve), .desvio(desvio),
      .destinoDesvio(destinoDesvio), .mem_req(mem_req), .mem_end(mem_end),
      .mem_pronto(mem_pronto), .mem_valido(mem_valido), .mem_dado(mem_dado),
      .instr_valida(instr_valida), .instrucao(instrucao), .instr_pc(instr_pc),
      .saidaAdder(saidaAdder), .id_pronto(id_pronto), .fila_nivel(fila_nivel)
   );

   busca_instrucao_fila #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .PCescreve(w_pce), .desvio(w_des),
      .destinoDesvio(w_tgt), .mem_req(w_req), .mem_end(w_end),
      .mem_pronto(w_mp), .mem_valido(w_mv), .mem_dado(w_dado),
      .instr_valida(w_iv), .instrucao(w_ins), .instr_pc(w_ipc),
      .saidaAdder(w_sa), .id_pronto(w_idp), .fila_nivel(w_niv)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      mq.delete();
      m_pc = 0;
      m_presp = 0;
      m_pend = 0;
      m_disc = 0;
   endtask

   // Entered and left at 1ns after a rising edge.
   task automatic do_reset();
      reset_n = 0; PCescreve = 1; desvio = 0; mem_valido = 0; mem_pronto = 1; w_pce = 1; w_mv = 0;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_end", mem_end, 0);
      chk("rst_instr_valida", instr_valida, 0);
      chk("rst_fila_nivel", fila_nivel, 0);
      chk("rst_instrucao", instrucao, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_saidaAdder", saidaAdder, 4);
      chk("rst_wrap_mem_end", w_end, 32'hFFFF_FFF8);
      chk("rst_wrap_saidaAdder", w_sa, 32'hFFFF_FFFC);
      chk("rst_wrap_mem_req", w_req, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      PCescreve = 0; mem_pronto = 0; w_pce = 0;
      reset_n = 1;
      @(posedge clock);
      #1;
      model_clear();
   endtask

   task automatic step(input bit p, input bit d, input logic [31:0] t, input bit i, input bit m);
      bit exp_req, acc, rsp;
      logic [31:0] a;
      PCescreve = p; desvio = d; destinoDesvio = t; id_pronto = i; mem_pronto = m;
      mem_valido = (mq.size() > 0) && (mq[0].due <= cyc);
      mem_dado = mem_valido ? 32'hA0 + mq[0].addr : $urandom;
      if (stray && mq.size() == 0 && $urandom_range(0, 7) == 0)
         mem_valido = 1;
      exp_req = p && !d && (m_pend + m_q.size() < 4);
      #1;
      chk("mem_req", mem_req, exp_req);
      chk("mem_end", mem_end, m_pc);
      chk("instr_valida", instr_valida, m_q.size() > 0);
      chk("fila_nivel", fila_nivel, m_q.size());
      if (m_q.size() > 0) begin
         chk("instr_pc", instr_pc, m_q[0].pc);
         chk("instrucao", instrucao, m_q[0].ins);
         chk("saidaAdder", saidaAdder, m_q[0].pc + 4);
      end
      if (mem_req && mem_pronto)
         n_acc++;
      @(posedge clock);
      acc = exp_req && m;
      rsp = mem_valido && m_pend > 0;
      a = m_pc;
      if (d) begin
         m_pc = t;
         m_presp = t;
         m_q.delete();
         if (rsp) m_pend--;
         m_disc = m_pend;
      end else begin
         if (acc) begin m_pc += 4; m_pend++; end
         if (m_q.size() > 0 && i) void'(m_q.pop_front());
         if (rsp) begin
            m_pend--;
            if (m_disc > 0) m_disc--;
            else begin
               m_q.push_back('{mem_dado, m_presp});
               m_presp += 4;
            end
         end
      end
      if (mem_valido && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back('{a, cyc + lat});
      cyc++;
      #1;
   endtask

   initial begin
      bit seen;
      logic [31:0] wb;
      tab[0]  = '{1,1,0,0,      1,0,0,       1,32'h0,   0,0,0,0};
      tab[1]  = '{1,1,0,0,      1,1,32'hA0,  1,32'h4,   0,0,0,0};
      tab[2]  = '{1,1,0,0,      1,1,32'hA4,  1,32'h8,   1,32'h0,32'hA0,1};
      tab[3]  = '{1,1,0,0,      1,1,32'hA8,  1,32'hC,   1,32'h4,32'hA4,1};
      tab[4]  = '{0,0,0,0,      1,1,32'hAC,  0,32'h10,  1,32'h8,32'hA8,1};
      tab[5]  = '{0,0,0,0,      1,0,0,       0,32'h10,  1,32'h8,32'hA8,2};
      tab[6]  = '{1,1,0,0,      0,0,0,       1,32'h10,  1,32'h8,32'hA8,2};
      tab[7]  = '{1,0,1,32'h100,1,0,0,       0,32'h10,  1,32'hC,32'hAC,1};
      tab[8]  = '{1,1,0,0,      1,0,0,       1,32'h100, 0,0,0,0};
      tab[9]  = '{1,1,0,0,      0,1,32'h1A0, 1,32'h104, 0,0,0,0};
      tab[10] = '{1,1,0,0,      0,0,0,       1,32'h104, 1,32'h100,32'h1A0,1};
      tab[11] = '{1,1,0,0,      0,0,0,       1,32'h104, 0,0,0,0};
      model_clear();
      @(posedge clock);
      #1;
      do_reset();

      for (int k = 0; k < 12; k++) begin
         PCescreve = tab[k].pce; id_pronto = tab[k].idp; desvio = tab[k].des;
         destinoDesvio = tab[k].tgt; mem_pronto = tab[k].mp; mem_valido = tab[k].mv; mem_dado = tab[k].dado;
         #1;
         chk($sformatf("tab%0d_mem_req", k), mem_req, tab[k].e_req);
         chk($sformatf("tab%0d_mem_end", k), mem_end, tab[k].e_end);
         chk($sformatf("tab%0d_instr_valida", k), instr_valida, tab[k].e_iv);
         chk($sformatf("tab%0d_fila_nivel", k), fila_nivel, tab[k].e_niv);
         if (tab[k].e_iv) begin
            chk($sformatf("tab%0d_instr_pc", k), instr_pc, tab[k].e_pc);
            chk($sformatf("tab%0d_instrucao", k), instrucao, tab[k].e_ins);
            chk($sformatf("tab%0d_saidaAdder", k), saidaAdder, tab[k].e_pc + 4);
         end
         @(posedge clock);
         #1;
      end

      // Queue fills with ID stalled, then drains in order.
      do_reset();
      lat = 1; n_acc = 0;
      repeat (8) step(1, 0, 0, 0, 1);
      chk("fill_accepts", n_acc, 4);
      chk("fill_nivel", fila_nivel, 4);
      chk("fill_mem_req", mem_req, 0);
      repeat (8) step(1, 0, 0, 1, 1);

      // Redirect with three requests in flight: their responses must never surface.
      do_reset();
      lat = 4;
      repeat (3) step(1, 0, 0, 1, 1);
      step(1, 1, 32'h100, 1, 1);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         step(1, 0, 0, 1, 1);
         if (instr_valida && !seen) begin
            seen = 1;
            chk("redir_first_pc", instr_pc, 32'h100);
         end
      end
      chk("redir_seen", seen, 1);

      // Redirect coinciding with a response and a pop.
      do_reset();
      lat = 1;
      repeat (2) step(1, 0, 0, 1, 1);
      step(1, 1, 32'h200, 1, 1);
      chk("redir_same_iv", instr_valida, 0);
      chk("redir_same_end", mem_end, 32'h200);
      chk("redir_same_nivel", fila_nivel, 0);
      repeat (6) step(1, 0, 0, 1, 1);

      // Stall with two outstanding requests.
      do_reset();
      lat = 3;
      repeat (2) step(1, 0, 0, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);
      chk("stall_nivel", fila_nivel, 2);
      chk("stall_end", mem_end, 32'h8);
      chk("stall_req", mem_req, 0);
      repeat (6) step(1, 0, 0, 1, 1);

      // Random traffic with stray responses and a mid-run reset.
      do_reset();
      stray = 1;
      for (int k = 0; k < 1500; k++) begin
         lat = $urandom_range(1, 4);
         if (k == 700) do_reset();
         step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      end
      stray = 0;

      // PC wraps past 2^32 without a bubble.
      do_reset();
      wb = 32'hFFFF_FFF8;
      for (int k = 0; k < 7; k++) begin
         w_pce = 1; w_mp = 1; w_idp = 1;
         w_mv = k >= 1;
         w_dado = wb + 32'(4 * (k - 1)) + 32'hA0;
         #1;
         chk($sformatf("wrap%0d_req", k), w_req, 1);
         chk($sformatf("wrap%0d_end", k), w_end, wb + 32'(4 * k));
         if (k >= 2) begin
            chk($sformatf("wrap%0d_iv", k), w_iv, 1);
            chk($sformatf("wrap%0d_pc", k), w_ipc, wb + 32'(4 * (k - 2)));
            chk($sformatf("wrap%0d_ins", k), w_ins, wb + 32'(4 * (k - 2)) + 32'hA0);
         end
         @(posedge clock);
         #1;
      end
      w_pce = 0; w_mv = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/busca_instrucao_fila.md
# busca_instrucao_fila

Parametrised instruction-fetch stage for the pipelined datapath: owns the PC, issues in-order read requests to the instruction memory over a ready/valid handshake, buffers returned instructions with their PC in a prefetch queue, and presents them to the ID stage. It generalises the single-port IF stage with configurable widths, queue depth, reset vector, PC increment, variable-latency memory, branch redirect with in-flight squash, and stall.

## Interface
- LARGURA, 32, instruction width
- LARGURA_END, 32, address/PC width
- PROFUNDIDADE, 4, prefetch queue depth; power of two, ≥2
- PC_RESET, 0, PC value after reset
- INCREMENTO, 4, PC step per fetch
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- PCescreve  in  1  1 = new requests may issue; 0 = freeze PC and issue (stall)
- desvio  in  1  redirect strobe (branch/jump resolved)
- destinoDesvio  in  LARGURA_END  redirect target
- mem_req  out  1  request valid
- mem_end  out  LARGURA_END  request address (= PC)
- mem_pronto  in  1  memory accepts request this cycle
- mem_valido  in  1  response valid, in request order
- mem_dado  in  LARGURA  response instruction
- instr_valida  out  1  queue head valid
- instrucao  out  LARGURA  head instruction
- instr_pc  out  LARGURA_END  head PC
- saidaAdder  out  LARGURA_END  instr_pc + INCREMENTO
- id_pronto  in  1  ID consumes head when instr_valida=1
- fila_nivel  out  clog2(PROFUNDIDADE+1)  queue occupancy

## Operation
- State: PC, queue (instruction + PC per entry, read/write pointers, count), pendentes (accepted requests without response), descartar (responses to squash), pcResposta (PC of next expected response).
- mem_req = PCescreve & ~desvio & (pendentes + fila_nivel < PROFUNDIDADE); mem_end = PC. Credit rule guarantees no overflow; pops in the same cycle give no credit.
- Accept (mem_req & mem_pronto): PC += INCREMENTO (modulo 2^LARGURA_END, wraps silently), pendentes++.
- Response (mem_valido): if descartar>0, drop it and descartar--; otherwise push {mem_dado, pcResposta}, pcResposta += INCREMENTO. pendentes-- in both cases.
- Pop: instr_valida & id_pronto, head advances.
- Redirect (desvio=1), highest priority: PC ← destinoDesvio, pcResposta ← destinoDesvio, queue emptied (a same-cycle pop or push is discarded), descartar ← pendentes after same-cycle accounting (pendentes minus 1 if a response arrives that cycle; that response is dropped). No request is accepted in a redirect cycle.
- Stall (PCescreve=0): no new requests; outstanding responses still land; queue still drains.
- mem_valido with pendentes=0 is a protocol error: ignored, counters unchanged.
- Push and pop in the same cycle: count unchanged, both pointers advance.

## Timing
- Reset (async assert, sync-safe deassert): PC=PC_RESET, pcResposta=PC_RESET, queue empty, pendentes=0, descartar=0; outputs instr_valida=0, fila_nivel=0, instrucao=0, instr_pc=PC_RESET, saidaAdder=PC_RESET+INCREMENTO, mem_req=0 while reset_n=0, mem_end=PC_RESET.
- First cycle after release with PCescreve=1: mem_req=1, mem_end=PC_RESET.
- Memory response at least 1 cycle after acceptance; response in cycle N → instr_valida=1 in N+1 (queue was empty).
- Redirect in cycle N → in N+1: instr_valida=0, mem_end=destinoDesvio, mem_req=1 if PCescreve=1 and credit allows.
- Throughput: one instruction per cycle at steady state with single-cycle memory and id_pronto=1.
- Reset mid-operation clears everything immediately; stale responses after reset are protocol errors (ignored).

## Test plan
- Reset, PCescreve=1, 1-cycle memory returning 0xA0+addr, id_pronto=1 -> instr_pc sequence 0x0,0x4,0x8,... one per cycle, instrucao matches, saidaAdder=instr_pc+4.
- id_pronto=0, PROFUNDIDADE=4 -> exactly 4 requests accepted, mem_req=0 afterwards, fila_nivel=4; release id_pronto -> drains in order, issue resumes.
- 3-cycle memory latency, 3 requests outstanding, desvio with destinoDesvio=0x100 -> 3 late responses dropped, first valid instr_pc=0x100, no 0x0/0x4/0x8 ever presented after redirect.
- Redirect in same cycle as mem_valido and a pop -> that response dropped, queue empty next cycle, mem_end=target.
- PCescreve=0 for 5 cycles with 2 outstanding -> both responses enqueue, PC frozen, mem_req=0; then resumes at next PC.
- PC_RESET=0xFFFFFFF8 -> PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap), no stall.
